// File: rtl/multiplier_pkg.sv
// Shared convolver defaults and lane helpers.
// Q-format sizing for the per-lane multiplier array.
package multiplier_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_KERNEL_SIZE = 5;
  localparam int DEF_FRAC_BITS   = 8;

  function automatic int unsigned lane_lsb(
    input int unsigned lane,
    input int unsigned width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/mult_lane.sv
// One signed fixed-point lane: multiply, floor-scale, register.
// Upper product bits beyond the Q range wrap away.
module mult_lane
  import multiplier_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH,
  parameter int F = DEF_FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] w_i,
  input  logic [W-1:0] p_i,
  output logic [W-1:0] res_o
);

  logic signed [2*W-1:0] w_x;
  logic signed [2*W-1:0] p_x;
  logic signed [2*W-1:0] prod;
  logic        [W-1:0]   res_d;
  logic        [W-1:0]   res_q;

  always_comb begin
    w_x   = {{W{w_i[W-1]}}, w_i};
    p_x   = {{W{p_i[W-1]}}, p_i};
    prod  = w_x * p_x;
    // arithmetic shift gives floor; the cast drops overflow bits
    res_d = W'(prod >>> F);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/multiplier.sv
// Parallel kernel-wide multiplier array.
// Unpacks lanes, instantiates mult_lane per lane, repacks.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  localparam int N = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*DATA_WIDTH-1:0] weights,
  input  logic [N*DATA_WIDTH-1:0] pixel_data,
  output logic [N*DATA_WIDTH-1:0] result
);

  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int unsigned LSB = lane_lsb(j, DATA_WIDTH);

    mult_lane #(
      .W (DATA_WIDTH),
      .F (FRAC_BITS)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .w_i   (weights[LSB +: DATA_WIDTH]),
      .p_i   (pixel_data[LSB +: DATA_WIDTH]),
      .res_o (result[LSB +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the multiplier lane array.
// Scoreboard of packed expected vectors, one per clock.
module tb_multiplier;

  localparam int W = 16;
  localparam int K = 5;
  localparam int F = 8;
  localparam int N = K * K;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] weights;
  logic [N*W-1:0] pixel_data;
  logic [N*W-1:0] result;

  int tests = 0;
  int fails = 0;

  logic [N*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  multiplier #(
    .DATA_WIDTH  (W),
    .KERNEL_SIZE (K),
    .FRAC_BITS   (F)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .weights    (weights),
    .pixel_data (pixel_data),
    .result     (result)
  );

  function automatic logic [W-1:0] model(
    input logic [W-1:0] w,
    input logic [W-1:0] p
  );
    logic signed [2*W-1:0] wx;
    logic signed [2*W-1:0] px;
    logic signed [2*W-1:0] pr;
    wx = {{W{w[W-1]}}, w};
    px = {{W{p[W-1]}}, p};
    pr = wx * px;
    return pr[F+W-1:F];
  endfunction

  task automatic chk(
    input string        tag,
    input logic [W-1:0] obs,
    input logic [W-1:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(
    input int           j,
    input logic [W-1:0] w,
    input logic [W-1:0] p
  );
    weights[j*W +: W]    = w;
    pixel_data[j*W +: W] = p;
  endtask

  task automatic tick(input string tag);
    logic [N*W-1:0] exp_v;
    for (int j = 0; j < N; j++) begin
      exp_v[j*W +: W] = model(weights[j*W +: W], pixel_data[j*W +: W]);
    end
    sb_q.push_back(exp_v);
    @(posedge clk);
    #1;
    tests++;
    assert (sb_q.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      exp_v = sb_q.pop_front();
      for (int j = 0; j < N; j++) begin
        chk($sformatf("%s_l%0d", tag, j), result[j*W +: W], exp_v[j*W +: W]);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int j = 0; j < N; j++) begin
      chk($sformatf("%s_l%0d", tag, j), result[j*W +: W], '0);
    end
  endtask

  task automatic randomize_all();
    for (int j = 0; j < N; j++) begin
      set_lane(j, W'($urandom), W'($urandom));
    end
  endtask

  initial begin
    weights    = '0;
    pixel_data = '0;
    rst_n      = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("por_async");
    @(posedge clk);
    #1;
    chk_zero("por_held");
    #2;
    rst_n = 1'b1;

    // directed Q8.8 cases, first edge after release
    set_lane(0,  16'h0100, 16'h0100);
    set_lane(3,  16'h0200, 16'h0180);
    set_lane(24, 16'hFF00, 16'h0100);
    set_lane(7,  16'hFFFF, 16'h0080);
    set_lane(12, 16'h7FFF, 16'h7FFF);
    tick("dir");
    chk("one_x_one",  result[0*W +: W],  16'h0100);
    chk("two_x_1p5",  result[3*W +: W],  16'h0300);
    chk("neg_one",    result[24*W +: W], 16'hFF00);
    chk("trunc",      result[7*W +: W],  16'hFFFF);
    chk("wrap",       result[12*W +: W], 16'hFF00);
    chk("idle_lane",  result[1*W +: W],  16'h0000);

    // hold until the next edge
    set_lane(0, 16'h0300, 16'h0200);
    #3;
    chk("hold_l0", result[0*W +: W], 16'h0100);

    // only lane 0 changed; neighbours must keep their values
    tick("indep");
    chk("indep_l0", result[0*W +: W],  16'h0600);
    chk("indep_l3", result[3*W +: W],  16'h0300);
    chk("indep_l7", result[7*W +: W],  16'hFFFF);

    for (int it = 0; it < 10; it++) begin
      randomize_all();
      tick($sformatf("rnd%0d", it));
    end

    // mid-stream reset between edges
    randomize_all();
    tick("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    sb_q.delete();
    #2;
    rst_n = 1'b1;
    set_lane(5, 16'h0200, 16'hFF00);
    tick("post_rst");
    chk("post_rst_l5", result[5*W +: W], 16'hFE00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
